// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXEC -> MEM -> WB.
// Supports the LOAD, OP-IMM, STORE and OP classes, with an optional memory-wait timeout.
module riscv_ctrl_fsm #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       op_i,
  input  logic [2:0]       funct3_i,
  input  logic [4:0]       rd_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             addr_sel_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             alu_src_imm_o,
  output logic             alu_force_add_o,
  output logic             rf_we_o,
  output logic             wb_sel_mem_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic [CNT_W-1:0] instret_o,
  output logic [2:0]       state_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam int         WW         = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WW-1:0] WAIT_LIM = WW'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [6:0]        op_q, op_d;
  logic [WW-1:0]     wait_q, wait_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic req, we, asel, irwe, pcwe, src_imm, force_add, rfwe, wbmem, ill, berr, retire;
  logic timeout;
  logic is_ls;

  // funct3 goes straight to the datapath; sequencing never looks at it.
  logic unused_funct3;
  assign unused_funct3 = ^funct3_i;

  // Memory handshake: a transfer completes in the cycle req=1 and mem_ready_i=1.
  // req holds steady until then, dropping early only on reset or timeout;
  // mem_ready_i while req=0 is ignored.
  assign timeout = (WAIT_MAX > 0) && req && !mem_ready_i && (wait_q == WAIT_LIM);
  assign is_ls   = (op_q == OPC_LOAD) || (op_q == OPC_STORE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      wait_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    req       = 1'b0;
    we        = 1'b0;
    asel      = 1'b0;
    irwe      = 1'b0;
    pcwe      = 1'b0;
    src_imm   = 1'b0;
    force_add = 1'b0;
    rfwe      = 1'b0;
    wbmem     = 1'b0;
    ill       = 1'b0;
    berr      = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (mem_ready_i) begin
          irwe    = 1'b1;
          pcwe    = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          berr = 1'b1;
        end
      end
      S_DECODE: begin
        op_d = op_i;
        if (op_i == OPC_LOAD || op_i == OPC_OPIMM || op_i == OPC_STORE || op_i == OPC_OP) begin
          state_d = S_EXEC;
        end else begin
          ill     = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        src_imm   = (op_q != OPC_OP);
        force_add = is_ls;
        state_d   = is_ls ? S_MEM : S_WB;
      end
      S_MEM: begin
        req  = 1'b1;
        asel = 1'b1;
        we   = (op_q == OPC_STORE);
        if (mem_ready_i) begin
          if (op_q == OPC_STORE) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          berr    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        rfwe    = (rd_i != 5'd0);
        wbmem   = (op_q == OPC_LOAD);
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Only FETCH and MEM request, so the count is already zero on entry to either.
  always_comb begin
    wait_d    = (req && !mem_ready_i && !timeout) ? wait_q + 1'b1 : '0;
    instret_d = retire ? instret_q + 1'b1 : instret_q;
  end

  assign mem_req_o       = req       & ~rst_i;
  assign mem_we_o        = we        & ~rst_i;
  assign addr_sel_o      = asel      & ~rst_i;
  assign ir_we_o         = irwe      & ~rst_i;
  assign pc_we_o         = pcwe      & ~rst_i;
  assign alu_src_imm_o   = src_imm   & ~rst_i;
  assign alu_force_add_o = force_add & ~rst_i;
  assign rf_we_o         = rfwe      & ~rst_i;
  assign wb_sel_mem_o    = wbmem     & ~rst_i;
  assign illegal_o       = ill       & ~rst_i;
  assign bus_err_o       = berr      & ~rst_i;
  assign instret_o       = rst_i ? '0 : instret_q;
  assign state_o         = rst_i ? 3'd0 : state_q;

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Directed-vector bench for riscv_ctrl_fsm: the driver queues the expected
// per-cycle output vector, a negedge monitor pops and compares it.
module tb_riscv_ctrl_fsm;

  localparam int W = 22;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OPR   = 7'b0110011;
  localparam logic [6:0] BAD   = 7'b1111111;

  // flag order: mem_req mem_we addr_sel ir_we pc_we alu_src_imm alu_force_add rf_we wb_sel_mem illegal bus_err
  localparam logic [10:0] F_NONE  = 11'b00000000000;
  localparam logic [10:0] F_FETCH = 11'b10011000000;
  localparam logic [10:0] F_FWAIT = 11'b10000000000;
  localparam logic [10:0] F_FERR  = 11'b10000000001;
  localparam logic [10:0] F_EXI   = 11'b00000100000;
  localparam logic [10:0] F_EXA   = 11'b00000110000;
  localparam logic [10:0] F_MEMR  = 11'b10100000000;
  localparam logic [10:0] F_MEMW  = 11'b11100000000;
  localparam logic [10:0] F_MERR  = 11'b10100000001;
  localparam logic [10:0] F_WB    = 11'b00000001000;
  localparam logic [10:0] F_WBL   = 11'b00000001100;
  localparam logic [10:0] F_ILL   = 11'b00000000010;

  logic        clk, rst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_we, pc_we, alu_src_imm, alu_force_add;
  logic        rf_we, wb_sel_mem, illegal, bus_err;
  logic [31:0] instret;
  logic [2:0]  state;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_vec = 0;
  int           n_err = 0;

  riscv_ctrl_fsm #(.CNT_W(32), .WAIT_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst), .op_i(op), .funct3_i(funct3), .rd_i(rd),
    .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .addr_sel_o(addr_sel), .ir_we_o(ir_we), .pc_we_o(pc_we),
    .alu_src_imm_o(alu_src_imm), .alu_force_add_o(alu_force_add),
    .rf_we_o(rf_we), .wb_sel_mem_o(wb_sel_mem), .illegal_o(illegal),
    .bus_err_o(bus_err), .instret_o(instret), .state_o(state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst = 1'b1; op = '0; funct3 = '0; rd = '0; mem_ready = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver
  task automatic step(input logic r, input logic [6:0] o, input logic [4:0] d,
                      input logic mr, input logic [2:0] st, input logic [10:0] fl,
                      input logic [7:0] ic, input string nm);
    @(posedge clk);
    #1;
    rst       = r;
    op        = o;
    rd        = d;
    mem_ready = mr;
    funct3    = 3'($urandom_range(7, 0));
    exp_q.push_back({st, fl, ic});
    name_q.push_back(nm);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] e, a;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {state, mem_req, mem_we, addr_sel, ir_we, pc_we, alu_src_imm,
            alu_force_add, rf_we, wb_sel_mem, illegal, bus_err, instret[7:0]};
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got state=%0d flags=%b instret=%0d, expected state=%0d flags=%b instret=%0d",
                 nm, a[21:19], a[18:8], a[7:0], e[21:19], e[18:8], e[7:0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(1, 7'd0, 5'd0, 1, 3'd0, F_NONE, 8'd0, "reset");
    step(0, OPIMM, 5'd5, 1, 3'd0, F_FETCH, 8'd0, "first_fetch");
    step(0, OPIMM, 5'd5, 1, 3'd1, F_NONE,  8'd0, "addi_dec");
    step(0, OPIMM, 5'd5, 1, 3'd2, F_EXI,   8'd0, "addi_exec");
    step(0, OPIMM, 5'd5, 1, 3'd4, F_WB,    8'd0, "addi_wb");

    step(0, LOAD, 5'd3, 1, 3'd0, F_FETCH, 8'd1, "lw_fetch");
    step(0, LOAD, 5'd3, 1, 3'd1, F_NONE,  8'd1, "lw_dec");
    step(0, LOAD, 5'd3, 1, 3'd2, F_EXA,   8'd1, "lw_exec");
    for (int i = 0; i < 2; i++) step(0, LOAD, 5'd3, 0, 3'd3, F_MEMR, 8'd1, "lw_mem_wait");
    step(0, LOAD, 5'd3, 1, 3'd3, F_MEMR,  8'd1, "lw_mem_done");
    step(0, LOAD, 5'd3, 1, 3'd4, F_WBL,   8'd1, "lw_wb");

    step(0, STORE, 5'd7, 1, 3'd0, F_FETCH, 8'd2, "sw_fetch");
    step(0, STORE, 5'd7, 1, 3'd1, F_NONE,  8'd2, "sw_dec");
    step(0, STORE, 5'd7, 1, 3'd2, F_EXA,   8'd2, "sw_exec");
    step(0, STORE, 5'd7, 1, 3'd3, F_MEMW,  8'd2, "sw_mem");

    step(0, OPR, 5'd0, 1, 3'd0, F_FETCH, 8'd3, "op_fetch");
    step(0, OPR, 5'd0, 1, 3'd1, F_NONE,  8'd3, "op_dec");
    step(0, OPR, 5'd0, 1, 3'd2, F_NONE,  8'd3, "op_exec");
    step(0, OPR, 5'd0, 1, 3'd4, F_NONE,  8'd3, "op_wb_rd0");

    step(0, BAD, 5'd9, 1, 3'd0, F_FETCH, 8'd4, "ill_fetch");
    step(0, BAD, 5'd9, 1, 3'd1, F_ILL,   8'd4, "ill_dec");

    for (int i = 0; i < 4; i++) step(0, OPIMM, 5'd1, 0, 3'd0, F_FWAIT, 8'd4, "fetch_wait");
    step(0, OPIMM, 5'd1, 0, 3'd0, F_FERR, 8'd4, "fetch_timeout");
    for (int i = 0; i < 4; i++) step(0, OPIMM, 5'd1, 0, 3'd0, F_FWAIT, 8'd4, "retry_wait");
    step(0, OPIMM, 5'd1, 1, 3'd0, F_FETCH, 8'd4, "retry_at_limit");
    step(0, OPIMM, 5'd1, 1, 3'd1, F_NONE,  8'd4, "retry_dec");
    step(0, OPIMM, 5'd1, 1, 3'd2, F_EXI,   8'd4, "retry_exec");
    step(0, OPIMM, 5'd1, 1, 3'd4, F_WB,    8'd4, "retry_wb");

    step(0, LOAD, 5'd2, 1, 3'd0, F_FETCH, 8'd5, "lwto_fetch");
    step(0, LOAD, 5'd2, 1, 3'd1, F_NONE,  8'd5, "lwto_dec");
    step(0, LOAD, 5'd2, 1, 3'd2, F_EXA,   8'd5, "lwto_exec");
    for (int i = 0; i < 4; i++) step(0, LOAD, 5'd2, 0, 3'd3, F_MEMR, 8'd5, "lwto_wait");
    step(0, LOAD, 5'd2, 0, 3'd3, F_MERR,  8'd5, "lwto_timeout");

    step(0, OPIMM, 5'd4, 1, 3'd0, F_FETCH, 8'd5, "abort_fetch");
    step(0, OPIMM, 5'd4, 1, 3'd1, F_NONE,  8'd5, "abort_dec");
    step(1, OPIMM, 5'd4, 1, 3'd0, F_NONE,  8'd0, "abort_reset");
    step(0, OPIMM, 5'd4, 1, 3'd0, F_FETCH, 8'd0, "post_reset_fetch");
    step(0, OPIMM, 5'd4, 1, 3'd1, F_NONE,  8'd0, "post_reset_dec");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
